// File: rtl/jtgng_inputs.sv
// Player-input conditioner: PS/2 key decode, joystick merge, SOCD cleaning,
// per-player autofire and coin pulses, and a pause toggle. Outputs active-low.
module jtgng_inputs #(
    parameter int PLAYERS     = 2,
    parameter int BUTTONS     = 2,
    parameter int JOYW        = BUTTONS + 7,
    parameter int AF_FRAMES   = 2,
    parameter int COIN_FRAMES = 3,
    parameter int SOCD_CLEAN  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          soft_rst,
    input  logic                          LVBL,
    input  logic [10:0]                   ps2_key,
    input  logic [PLAYERS*JOYW-1:0]       joy_in,
    input  logic                          merge,
    input  logic [PLAYERS-1:0]            autofire_en,
    output logic [PLAYERS*(BUTTONS+4)-1:0] joystick,
    output logic [PLAYERS-1:0]            start_button,
    output logic [PLAYERS-1:0]            coin_input,
    output logic                          dip_pause
);

    localparam int JW = BUTTONS + 4;
    localparam int BS = BUTTONS + 4;
    localparam int BC = BUTTONS + 5;
    localparam int BP = BUTTONS + 6;
    localparam logic [3:0] AF_LAST   = 4'(AF_FRAMES - 1);
    localparam logic [3:0] COIN_LAST = 4'(COIN_FRAMES - 1);

    logic            ps2_tog_q;
    logic            lvbl_q;
    logic            ps2_evt;
    logic            frame_tick;
    logic            unused_ext;

    logic k_up, k_down, k_left, k_right;
    logic k_b0, k_b1a, k_b1b, k_b2, k_b3;
    logic k_start1, k_start2, k_coin1, k_coin2, k_pause;

    logic [3:0]      kb_btn;
    logic [JOYW-1:0] joy_or;
    logic [JOYW-1:0] kbd;
    logic [JOYW-1:0] w;
    logic [JOYW-1:0] raw [PLAYERS];
    logic            pause_any;

    logic [JW-1:0]   joy_q [PLAYERS];
    logic [3:0]      af_cnt [PLAYERS];
    logic [3:0]      coin_cnt [PLAYERS];
    logic [PLAYERS-1:0] start_q;
    logic [PLAYERS-1:0] btn0_q;
    logic [PLAYERS-1:0] af_out;
    logic [PLAYERS-1:0] coin_q;
    logic [PLAYERS-1:0] coin_act;
    logic            pause_q;
    logic            pause_flag;
    logic [JW-1:0]   jo;

    // The extended-code flag carries no meaning for this key map.
    assign unused_ext = ps2_key[8];

    assign ps2_evt    = ps2_key[10] ^ ps2_tog_q;
    assign frame_tick = lvbl_q & ~LVBL;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps2_tog_q <= 1'b0;
            lvbl_q    <= 1'b0;
            k_up      <= 1'b0;
            k_down    <= 1'b0;
            k_left    <= 1'b0;
            k_right   <= 1'b0;
            k_b0      <= 1'b0;
            k_b1a     <= 1'b0;
            k_b1b     <= 1'b0;
            k_b2      <= 1'b0;
            k_b3      <= 1'b0;
            k_start1  <= 1'b0;
            k_start2  <= 1'b0;
            k_coin1   <= 1'b0;
            k_coin2   <= 1'b0;
            k_pause   <= 1'b0;
        end else begin
            ps2_tog_q <= ps2_key[10];
            lvbl_q    <= LVBL;
            if (ps2_evt) begin
                case (ps2_key[7:0])
                    8'h75:   k_up     <= ps2_key[9];
                    8'h72:   k_down   <= ps2_key[9];
                    8'h6B:   k_left   <= ps2_key[9];
                    8'h74:   k_right  <= ps2_key[9];
                    8'h14:   k_b0     <= ps2_key[9];
                    8'h11:   k_b1a    <= ps2_key[9];
                    8'h29:   k_b1b    <= ps2_key[9];
                    8'h12:   k_b2     <= ps2_key[9];
                    8'h1A:   k_b3     <= ps2_key[9];
                    8'h05:   k_start1 <= ps2_key[9];
                    8'h06:   k_start2 <= ps2_key[9];
                    8'h04:   k_coin1  <= ps2_key[9];
                    8'h36:   k_coin2  <= ps2_key[9];
                    8'h0C:   k_pause  <= ps2_key[9];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        kb_btn    = {k_b3, k_b2, k_b1a | k_b1b, k_b0};
        joy_or    = '0;
        kbd       = '0;
        w         = '0;
        pause_any = 1'b0;
        raw       = '{default: '0};
        for (int p = 0; p < PLAYERS; p++) begin
            joy_or = joy_or | joy_in[p*JOYW +: JOYW];
        end
        for (int p = 0; p < PLAYERS; p++) begin
            kbd = '0;
            if (p == 0) begin
                kbd[3:0]          = {k_up, k_down, k_left, k_right};
                kbd[4 +: BUTTONS] = kb_btn[BUTTONS-1:0];
                kbd[BS]           = k_start1;
                kbd[BC]           = k_coin1;
                kbd[BP]           = k_pause;
            end else if (p == 1) begin
                kbd[BS] = k_start2;
                kbd[BC] = k_coin2;
            end
            w = (merge ? joy_or : joy_in[p*JOYW +: JOYW]) | kbd;
            // Opposing directions cancel after merging so shared sticks clean too.
            if (SOCD_CLEAN != 0) begin
                if (w[0] && w[1]) w[1:0] = 2'b00;
                if (w[2] && w[3]) w[3:2] = 2'b00;
            end
            raw[p]    = w;
            pause_any = pause_any | w[BP];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < PLAYERS; p++) begin
                joy_q[p]    <= '0;
                af_cnt[p]   <= '0;
                coin_cnt[p] <= '0;
            end
            start_q  <= '0;
            btn0_q   <= '0;
            af_out   <= '0;
            coin_q   <= '0;
            coin_act <= '0;
        end else begin
            for (int p = 0; p < PLAYERS; p++) begin
                joy_q[p]   <= raw[p][JW-1:0];
                start_q[p] <= raw[p][BS];
                btn0_q[p]  <= raw[p][4];
                coin_q[p]  <= raw[p][BC];

                if (!autofire_en[p] || !raw[p][4]) begin
                    af_out[p] <= 1'b0;
                    af_cnt[p] <= '0;
                end else if (!btn0_q[p]) begin
                    af_out[p] <= 1'b1;
                    af_cnt[p] <= '0;
                end else if (frame_tick) begin
                    if (af_cnt[p] == AF_LAST) begin
                        af_out[p] <= ~af_out[p];
                        af_cnt[p] <= '0;
                    end else begin
                        af_cnt[p] <= af_cnt[p] + 4'd1;
                    end
                end

                // A press during a running pulse is swallowed; re-arm needs a fresh edge.
                if (coin_act[p]) begin
                    if (frame_tick) begin
                        if (coin_cnt[p] == COIN_LAST) begin
                            coin_act[p] <= 1'b0;
                            coin_cnt[p] <= '0;
                        end else begin
                            coin_cnt[p] <= coin_cnt[p] + 4'd1;
                        end
                    end
                end else if (raw[p][BC] && !coin_q[p]) begin
                    coin_act[p] <= 1'b1;
                    coin_cnt[p] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pause_q    <= 1'b0;
            pause_flag <= 1'b0;
        end else begin
            pause_q <= pause_any;
            if (soft_rst) begin
                pause_flag <= 1'b0;
            end else if (pause_any && !pause_q) begin
                pause_flag <= ~pause_flag;
            end
        end
    end

    always_comb begin
        jo           = '0;
        joystick     = '1;
        start_button = '1;
        coin_input   = '1;
        for (int p = 0; p < PLAYERS; p++) begin
            jo = joy_q[p];
            if (autofire_en[p]) jo[4] = af_out[p];
            joystick[p*JW +: JW] = ~jo;
            start_button[p]      = ~start_q[p];
            coin_input[p]        = ~coin_act[p];
        end
        dip_pause = ~pause_flag;
    end

endmodule

// File: tb/tb_jtgng_inputs.sv
// Directed bench for jtgng_inputs at default parameters (2 players, 2 buttons,
// AF_FRAMES=2, COIN_FRAMES=3, SOCD cleaning on).
module tb_jtgng_inputs;

    logic        clk = 1'b0;
    logic        rst;
    logic        soft_rst;
    logic        LVBL;
    logic [10:0] ps2_key;
    logic [17:0] joy_in;
    logic        merge;
    logic [1:0]  autofire_en;
    logic [11:0] joystick;
    logic [1:0]  start_button;
    logic [1:0]  coin_input;
    logic        dip_pause;

    int n_checks = 0;
    int n_fail   = 0;

    jtgng_inputs dut (
        .clk          (clk),
        .rst          (rst),
        .soft_rst     (soft_rst),
        .LVBL         (LVBL),
        .ps2_key      (ps2_key),
        .joy_in       (joy_in),
        .merge        (merge),
        .autofire_en  (autofire_en),
        .joystick     (joystick),
        .start_button (start_button),
        .coin_input   (coin_input),
        .dip_pause    (dip_pause)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame();
        LVBL = 1'b0;
        step(1);
        LVBL = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        rst = 1'b1; soft_rst = 1'b0; LVBL = 1'b1; ps2_key = '0;
        joy_in = '0; merge = 1'b0; autofire_en = '0;
        step(2);
        n_checks++;
        if (joystick !== 12'hFFF) begin n_fail++; $display("FAIL reset_joystick got %h want %h", joystick, 12'hFFF); end
        n_checks++;
        if (start_button !== 2'b11) begin n_fail++; $display("FAIL reset_start got %b want %b", start_button, 2'b11); end
        n_checks++;
        if (coin_input !== 2'b11) begin n_fail++; $display("FAIL reset_coin got %b want %b", coin_input, 2'b11); end
        n_checks++;
        if (dip_pause !== 1'b1) begin n_fail++; $display("FAIL reset_pause got %b want %b", dip_pause, 1'b1); end
        rst = 1'b0;
        step(2);
        n_checks++;
        if (joystick !== 12'hFFF) begin n_fail++; $display("FAIL idle_joystick got %h want %h", joystick, 12'hFFF); end
    endtask

    task automatic test_joy();
        joy_in = 18'h0_0008 | (18'h1 << 15);
        step(1);
        n_checks++;
        if (joystick !== 12'hFF7) begin n_fail++; $display("FAIL joy_up_p1 got %h want %h", joystick, 12'hFF7); end
        n_checks++;
        if (start_button !== 2'b01) begin n_fail++; $display("FAIL joy_start_p2 got %b want %b", start_button, 2'b01); end
        joy_in = '0;
        step(1);
        n_checks++;
        if (joystick !== 12'hFFF || start_button !== 2'b11) begin
            n_fail++; $display("FAIL joy_release got %h/%b want fff/11", joystick, start_button);
        end
    endtask

    task automatic test_ps2();
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h74};
        step(1);
        n_checks++;
        if (joystick[0] !== 1'b1) begin n_fail++; $display("FAIL ps2_right_1clk got %b want %b", joystick[0], 1'b1); end
        step(1);
        n_checks++;
        if (joystick !== 12'hFFE) begin n_fail++; $display("FAIL ps2_right_2clk got %h want %h", joystick, 12'hFFE); end
        ps2_key = {1'b1, 1'b0, 1'b0, 8'h74};
        step(2);
        n_checks++;
        if (joystick[0] !== 1'b0) begin n_fail++; $display("FAIL ps2_no_event got %b want %b", joystick[0], 1'b0); end
        ps2_key = {1'b0, 1'b0, 1'b0, 8'h74};
        step(1);
        n_checks++;
        if (joystick[0] !== 1'b0) begin n_fail++; $display("FAIL ps2_release_1clk got %b want %b", joystick[0], 1'b0); end
        step(1);
        n_checks++;
        if (joystick[0] !== 1'b1) begin n_fail++; $display("FAIL ps2_release_2clk got %b want %b", joystick[0], 1'b1); end
        ps2_key = {1'b1, 1'b1, 1'b1, 8'h06};
        step(2);
        n_checks++;
        if (start_button !== 2'b01) begin n_fail++; $display("FAIL ps2_start2 got %b want %b", start_button, 2'b01); end
        ps2_key = {1'b0, 1'b0, 1'b0, 8'h06};
        step(2);
        n_checks++;
        if (start_button !== 2'b11) begin n_fail++; $display("FAIL ps2_start2_rel got %b want %b", start_button, 2'b11); end
    endtask

    task automatic test_socd_merge();
        joy_in = 18'h0_0003;
        step(1);
        n_checks++;
        if (joystick !== 12'hFFF) begin n_fail++; $display("FAIL socd_lr got %h want %h", joystick, 12'hFFF); end
        joy_in = 18'h0_000E;
        step(1);
        n_checks++;
        if (joystick !== 12'hFFD) begin n_fail++; $display("FAIL socd_ud_left got %h want %h", joystick, 12'hFFD); end
        joy_in = 18'h1 << 12;
        merge  = 1'b1;
        step(1);
        n_checks++;
        if (joystick !== 12'hDF7) begin n_fail++; $display("FAIL merge_up got %h want %h", joystick, 12'hDF7); end
        merge = 1'b0;
        step(1);
        n_checks++;
        if (joystick !== 12'hDFF) begin n_fail++; $display("FAIL unmerge_up got %h want %h", joystick, 12'hDFF); end
        joy_in = '0;
        step(1);
    endtask

    task automatic test_autofire();
        logic want;
        autofire_en = 2'b01;
        joy_in = 18'h0_0010;
        step(1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) frame();
            want = ((k / 2) % 2) != 0;
            n_checks++;
            if (joystick[4] !== want) begin
                n_fail++; $display("FAIL autofire_frame%0d got %b want %b", k, joystick[4], want);
            end
        end
        joy_in = '0;
        step(1);
        n_checks++;
        if (joystick[4] !== 1'b1) begin n_fail++; $display("FAIL autofire_release got %b want %b", joystick[4], 1'b1); end
        autofire_en = 2'b00;
        joy_in = 18'h0_0010;
        step(1);
        frame();
        frame();
        n_checks++;
        if (joystick[4] !== 1'b0) begin n_fail++; $display("FAIL autofire_off_pass got %b want %b", joystick[4], 1'b0); end
        joy_in = '0;
        step(1);
    endtask

    task automatic test_coin();
        logic [1:0] want;
        joy_in = 18'h0_0080;
        step(1);
        n_checks++;
        if (coin_input !== 2'b10) begin n_fail++; $display("FAIL coin_start got %b want %b", coin_input, 2'b10); end
        for (int k = 1; k <= 10; k++) begin
            frame();
            want = (k < 3) ? 2'b10 : 2'b11;
            n_checks++;
            if (coin_input !== want) begin
                n_fail++; $display("FAIL coin_frame%0d got %b want %b", k, coin_input, want);
            end
        end
        joy_in = '0;
        step(1);
        joy_in = 18'h0_0080;
        step(1);
        n_checks++;
        if (coin_input !== 2'b10) begin n_fail++; $display("FAIL coin_rearm got %b want %b", coin_input, 2'b10); end
        joy_in = '0;
        rst = 1'b1;
        step(1);
        n_checks++;
        if (coin_input !== 2'b11) begin n_fail++; $display("FAIL coin_reset_abort got %b want %b", coin_input, 2'b11); end
        rst = 1'b0;
        step(2);
        n_checks++;
        if (coin_input !== 2'b11) begin n_fail++; $display("FAIL coin_after_reset got %b want %b", coin_input, 2'b11); end
    endtask

    task automatic test_pause();
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h0C};
        step(2);
        n_checks++;
        if (dip_pause !== 1'b0) begin n_fail++; $display("FAIL pause_press1 got %b want %b", dip_pause, 1'b0); end
        ps2_key = {1'b0, 1'b0, 1'b0, 8'h0C};
        step(2);
        n_checks++;
        if (dip_pause !== 1'b0) begin n_fail++; $display("FAIL pause_release got %b want %b", dip_pause, 1'b0); end
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h0C};
        step(2);
        n_checks++;
        if (dip_pause !== 1'b1) begin n_fail++; $display("FAIL pause_press2 got %b want %b", dip_pause, 1'b1); end
        ps2_key = {1'b0, 1'b0, 1'b0, 8'h0C};
        step(2);
        joy_in   = 18'h0_0100;
        soft_rst = 1'b1;
        step(1);
        n_checks++;
        if (dip_pause !== 1'b1) begin n_fail++; $display("FAIL pause_softrst_prio got %b want %b", dip_pause, 1'b1); end
        soft_rst = 1'b0;
        joy_in   = '0;
        step(1);
        joy_in = 18'h1 << 17;
        step(1);
        n_checks++;
        if (dip_pause !== 1'b0) begin n_fail++; $display("FAIL pause_p2 got %b want %b", dip_pause, 1'b0); end
        joy_in = '0;
        step(1);
        soft_rst = 1'b1;
        step(1);
        n_checks++;
        if (dip_pause !== 1'b1) begin n_fail++; $display("FAIL pause_softrst got %b want %b", dip_pause, 1'b1); end
        soft_rst = 1'b0;
        step(1);
    endtask

    initial begin
        test_reset();
        test_joy();
        test_ps2();
        test_socd_merge();
        test_autofire();
        test_coin();
        test_pause();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
